// File: rtl/fifo_wrrouter_multichannel_if.sv
// Write-stream and per-channel read/status bundle for fifo_wrrouter_multichannel.
// i_wr_broadcast exists only when FIFO_WRROUTER_BROADCAST_EN is defined.
interface fifo_wrrouter_multichannel_if #(
    parameter int unsigned CHANNEL_WIDTH  = 32,
    parameter int unsigned CHANNEL_DEPTH  = 1024,
    parameter int unsigned CHANNELS_CNT   = 3,
    parameter int unsigned DROP_CNT_WIDTH = 16
);
    localparam int unsigned SEL_W  = $clog2(CHANNELS_CNT);
    localparam int unsigned FILL_W = $clog2(CHANNEL_DEPTH) + 1;

    logic [SEL_W-1:0]                             i_channel_wr_select;
    logic                                         i_wr_valid;
    logic [CHANNEL_WIDTH-1:0]                     i_wr_data;
    logic                                         o_wr_ready;
`ifdef FIFO_WRROUTER_BROADCAST_EN
    logic                                         i_wr_broadcast;
`endif
    logic [CHANNELS_CNT-1:0]                      i_rd_en_channels;
    logic [CHANNELS_CNT-1:0]                      o_rd_valid_channels;
    logic [CHANNELS_CNT-1:0][CHANNEL_WIDTH-1:0]   o_rd_data_channels;
    logic [CHANNELS_CNT-1:0]                      o_empty_channels;
    logic [CHANNELS_CNT-1:0]                      o_full_channels;
    logic [CHANNELS_CNT-1:0][FILL_W-1:0]          o_fill_count_channels;
    logic [CHANNELS_CNT-1:0][DROP_CNT_WIDTH-1:0]  o_drop_count_channels;
    logic                                         o_err_sel_sticky;

    modport master (
`ifdef FIFO_WRROUTER_BROADCAST_EN
        output i_wr_broadcast,
`endif
        output i_channel_wr_select, i_wr_valid, i_wr_data, i_rd_en_channels,
        input  o_wr_ready, o_rd_valid_channels, o_rd_data_channels, o_empty_channels,
        input  o_full_channels, o_fill_count_channels, o_drop_count_channels, o_err_sel_sticky
    );

    modport slave (
`ifdef FIFO_WRROUTER_BROADCAST_EN
        input  i_wr_broadcast,
`endif
        input  i_channel_wr_select, i_wr_valid, i_wr_data, i_rd_en_channels,
        output o_wr_ready, o_rd_valid_channels, o_rd_data_channels, o_empty_channels,
        output o_full_channels, o_fill_count_channels, o_drop_count_channels, o_err_sel_sticky
    );
endinterface

// File: rtl/fifo_wrrouter_multichannel.sv
// Channel-addressed write router feeding CHANNELS_CNT circular FIFOs through one stage register.
// Optional broadcast write mode enabled by defining FIFO_WRROUTER_BROADCAST_EN.
module fifo_wrrouter_multichannel #(
    parameter int unsigned CHANNEL_WIDTH  = 32,
    parameter int unsigned CHANNEL_DEPTH  = 1024,
    parameter int unsigned CHANNELS_CNT   = 3,
    parameter int unsigned DROP_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_all,
    input  logic [CHANNELS_CNT-1:0]  rst_channels,
    fifo_wrrouter_multichannel_if.slave bus
);
    localparam int unsigned SEL_W  = $clog2(CHANNELS_CNT);
    localparam int unsigned PTR_W  = $clog2(CHANNEL_DEPTH);
    localparam int unsigned FILL_W = PTR_W + 1;
    localparam int unsigned SUM_W  = FILL_W + 1;

    logic [CHANNEL_WIDTH-1:0] mem [CHANNELS_CNT][CHANNEL_DEPTH];

    logic [CHANNELS_CNT-1:0][PTR_W-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CHANNELS_CNT-1:0][FILL_W-1:0]         fill_q, fill_d;
    logic [CHANNELS_CNT-1:0][DROP_CNT_WIDTH-1:0] drop_q, drop_d;
    logic [CHANNELS_CNT-1:0][CHANNEL_WIDTH-1:0]  rd_data_q, rd_data_d;
    logic [CHANNELS_CNT-1:0]                     empty_q, empty_d, full_q, full_d;
    logic [CHANNELS_CNT-1:0]                     rd_valid_q, rd_valid_d;
    logic [CHANNELS_CNT-1:0]                     stage_mask_q, stage_mask_d;
    logic [CHANNEL_WIDTH-1:0]                    stage_data_q, stage_data_d;
    logic                                        err_q, err_d;

    logic [CHANNELS_CNT-1:0] ch_ready_c, accept_c, drop_hit_c, commit_c, pop_c;
    logic                    sel_ok_c, wr_ready_c, bcast_c;

`ifdef FIFO_WRROUTER_BROADCAST_EN
    assign bcast_c = bus.i_wr_broadcast;
`else
    assign bcast_c = 1'b0;
`endif

    // A channel has room when committed entries plus its in-flight staged beat leave a free slot.
    always_comb begin
        ch_ready_c = '0;
        for (int c = 0; c < CHANNELS_CNT; c++) begin
            ch_ready_c[c] = (SUM_W'(fill_q[c]) + SUM_W'(stage_mask_q[c])) < SUM_W'(CHANNEL_DEPTH);
        end
    end

    // Write routing: stage mask of accepting channels, drop hits, invalid-select flag.
    always_comb begin
        sel_ok_c   = 32'(bus.i_channel_wr_select) < CHANNELS_CNT;
        wr_ready_c = 1'b0;
        accept_c   = '0;
        drop_hit_c = '0;
        err_d      = err_q;
        if (bcast_c) begin
            wr_ready_c = &ch_ready_c;
            if (bus.i_wr_valid) begin
                accept_c   = ch_ready_c;
                drop_hit_c = ~ch_ready_c;
            end
        end else begin
            for (int c = 0; c < CHANNELS_CNT; c++) begin
                if (sel_ok_c && bus.i_channel_wr_select == SEL_W'(c)) begin
                    wr_ready_c = ch_ready_c[c];
                    if (bus.i_wr_valid) begin
                        accept_c[c]   = ch_ready_c[c];
                        drop_hit_c[c] = ~ch_ready_c[c];
                    end
                end
            end
            if (bus.i_wr_valid && !sel_ok_c) begin
                err_d = 1'b1;
            end
        end
        stage_mask_d = accept_c;
        stage_data_d = (|accept_c) ? bus.i_wr_data : stage_data_q;
    end

    // Per-channel commit/pop bookkeeping; a channel flush overrides everything on that channel.
    always_comb begin
        commit_c   = '0;
        pop_c      = '0;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        fill_d     = fill_q;
        drop_d     = drop_q;
        rd_valid_d = '0;
        rd_data_d  = rd_data_q;
        empty_d    = empty_q;
        full_d     = full_q;
        for (int c = 0; c < CHANNELS_CNT; c++) begin
            commit_c[c] = stage_mask_q[c] & ~rst_channels[c];
            pop_c[c]    = bus.i_rd_en_channels[c] & ~empty_q[c] & ~rst_channels[c];
            wptr_d[c]   = wptr_q[c] + PTR_W'(commit_c[c]);
            rptr_d[c]   = rptr_q[c] + PTR_W'(pop_c[c]);
            fill_d[c]   = fill_q[c] + FILL_W'(commit_c[c]) - FILL_W'(pop_c[c]);
            rd_valid_d[c] = pop_c[c];
            if (pop_c[c]) begin
                rd_data_d[c] = mem[c][rptr_q[c]];
            end
            if (drop_hit_c[c] && drop_q[c] != '1) begin
                drop_d[c] = drop_q[c] + DROP_CNT_WIDTH'(1);
            end
            if (rst_channels[c]) begin
                wptr_d[c] = '0;
                rptr_d[c] = '0;
                fill_d[c] = '0;
                drop_d[c] = '0;
            end
            empty_d[c] = (fill_d[c] == '0);
            full_d[c]  = (fill_d[c] == FILL_W'(CHANNEL_DEPTH));
        end
    end

    always_ff @(posedge clk or negedge rst_all) begin
        if (!rst_all) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            fill_q       <= '0;
            drop_q       <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= '0;
            empty_q      <= '1;
            full_q       <= '0;
            stage_mask_q <= '0;
            stage_data_q <= '0;
            err_q        <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            fill_q       <= fill_d;
            drop_q       <= drop_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            empty_q      <= empty_d;
            full_q       <= full_d;
            stage_mask_q <= stage_mask_d;
            stage_data_q <= stage_data_d;
            err_q        <= err_d;
        end
    end

    // Storage is not reset; only entries between the pointers are ever observed.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS_CNT; c++) begin
            if (commit_c[c]) begin
                mem[c][wptr_q[c]] <= stage_data_q;
            end
        end
    end

    assign bus.o_wr_ready            = wr_ready_c;
    assign bus.o_rd_valid_channels   = rd_valid_q;
    assign bus.o_rd_data_channels    = rd_data_q;
    assign bus.o_empty_channels      = empty_q;
    assign bus.o_full_channels       = full_q;
    assign bus.o_fill_count_channels = fill_q;
    assign bus.o_drop_count_channels = drop_q;
    assign bus.o_err_sel_sticky      = err_q;
endmodule
